gbuff_bank: RTL

Parametrised successor to the TPU global buffer: a single-port-per-direction SRAM-style word buffer with independent write and read channels, valid/ready handshakes, per-byte write mask, and a configurable read latency. Contents are zeroed by a hardware clear engine, one word per cycle, after reset and on request. The array is never cleared in a single cycle. The block sits between the TPU controller/DMA and the systolic-array feeders and replaces the fixed 256×32 buffer.

---
 rtl/gbuff_bank_pkg.sv | 18 +
 rtl/gbuff_clr_ctrl.sv | 59 +++++
 rtl/gbuff_bank.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gbuff_bank_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the global word buffer.
package gbuff_bank_pkg;

    localparam int GB_WORD_SIZE = 32;
    localparam int GB_DEPTH     = 256;
    localparam int GB_RD_LAT    = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } gb_state_e;

    // Address width for a given depth; a single-word buffer still needs one bit.
    function automatic int gb_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gbuff_clr_ctrl.sv
// Clear engine: sweeps the array to zero one word per cycle and gates both
// request channels while it runs.
module gbuff_clr_ctrl
    import gbuff_bank_pkg::*;
#(
    parameter int DEPTH  = GB_DEPTH,
    parameter int ADDR_W = gb_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              busy,
    output logic              wr_ready,
    output logic              rd_ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    gb_state_e         state_r;
    logic [ADDR_W-1:0] clr_ptr_r;

    // Sweep FSM; clr_start is only honoured in IDLE so a running sweep never restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_ptr_r == LAST_ADDR) begin
                        state_r   <= ST_IDLE;
                        clr_ptr_r <= '0;
                    end else begin
                        clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr_start) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= '0;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= '0;
                end
            endcase
        end
    end

    assign busy     = (state_r == ST_CLEAR);
    assign wr_ready = (state_r == ST_IDLE);
    assign rd_ready = (state_r == ST_IDLE);
    assign clr_we   = busy;
    assign clr_addr = clr_ptr_r;

endmodule

// File: rtl/gbuff_bank.sv
// Global word buffer: independent write/read channels with byte masks,
// write-first bypass, RD_LAT-stage read pipeline and a hardware clear engine.
module gbuff_bank
    import gbuff_bank_pkg::*;
#(
    parameter int WORD_SIZE = GB_WORD_SIZE,
    parameter int DEPTH     = GB_DEPTH,
    parameter int ADDR_W    = gb_addr_w(DEPTH),
    parameter int RD_LAT    = GB_RD_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_start,
    output logic                   busy,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WORD_SIZE-1:0]   wr_data,
    input  logic [WORD_SIZE/8-1:0] wr_mask,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_data_valid,
    output logic [WORD_SIZE-1:0]   rd_data
);

    localparam int              NB      = WORD_SIZE / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    function automatic logic [WORD_SIZE-1:0] merge_bytes(
        input logic [WORD_SIZE-1:0] old_word,
        input logic [WORD_SIZE-1:0] new_word,
        input logic [NB-1:0]        mask
    );
        logic [WORD_SIZE-1:0] res;
        res = old_word;
        for (int k = 0; k < NB; k++) begin
            if (mask[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic                 clr_we_s;
    logic [ADDR_W-1:0]    clr_addr_s;
    logic                 wr_fire_s;
    logic                 rd_fire_s;
    logic                 wr_in_range_s;
    logic                 rd_in_range_s;
    logic [WORD_SIZE-1:0] merged_s;
    logic [WORD_SIZE-1:0] rd_word_s;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [RD_LAT-1:0]    pipe_vld_r;
    logic [WORD_SIZE-1:0] pipe_dat_r [RD_LAT];

    gbuff_clr_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .busy      (busy),
        .wr_ready  (wr_ready),
        .rd_ready  (rd_ready),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s)
    );

    assign wr_fire_s     = wr_valid & wr_ready;
    assign rd_fire_s     = rd_valid & rd_ready;
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);

    // Mask merge and read sampling; a same-address write in this cycle is forwarded.
    always_comb begin
        merged_s  = '0;
        rd_word_s = '0;
        if (wr_in_range_s) begin
            merged_s = merge_bytes(mem[wr_addr], wr_data, wr_mask);
        end else begin
            merged_s = '0;
        end
        if (!rd_in_range_s) begin
            rd_word_s = '0;
        end else if (wr_fire_s && wr_in_range_s && (wr_addr == rd_addr)) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = mem[rd_addr];
        end
    end

    // Array update; writes are only accepted in IDLE, so they never collide with the sweep.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem[clr_addr_s] <= '0;
        end else if (wr_fire_s && wr_in_range_s) begin
            mem[wr_addr] <= merged_s;
        end
    end

    // Read pipeline; data stages load only behind a valid so the output word holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_dat_r[i] <= '0;
            end
        end else begin
            pipe_vld_r[0] <= rd_fire_s;
            if (rd_fire_s) begin
                pipe_dat_r[0] <= rd_word_s;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                if (pipe_vld_r[i-1]) begin
                    pipe_dat_r[i] <= pipe_dat_r[i-1];
                end
            end
        end
    end

    assign rd_data_valid = pipe_vld_r[RD_LAT-1];
    assign rd_data       = pipe_dat_r[RD_LAT-1];

endmodule
